uart_tx_arbiter: RTL

Shares the board's single UART transmit line between two byte-stream requesters, typically the SoC's UART and a hardware status/debug reporter. It arbitrates round-robin at message granularity, so a requester keeps the line until it marks its last byte. It also serializes the winning byte as 8N1 onto `io_tx`. It sits between the SoC and the FTDI transmit pin in the board top level.

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmit arbiter: message-granular round-robin lock plus 8N1 serializer.
// Back-to-back frames are accepted in the final stop-bit cycle, so there is no gap between them.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_req0_valid,
  input  logic [7:0] io_req0_data,
  input  logic       io_req0_last,
  output logic       io_req0_ready,
  input  logic       io_req1_valid,
  input  logic [7:0] io_req1_data,
  input  logic       io_req1_last,
  output logic       io_req1_ready,
  output logic [1:0] io_grant,
  output logic       io_busy,
  output logic       io_tx
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO_W = 21;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [1:0]       owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             bit_end_c, window_c, sel_c, sel_vld_c, accept_c, acc_last_c;
  logic [7:0]       acc_data_c;
  logic [TMO_W-1:0] tmo_inc_c;

  assign bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign window_c  = (state_q == IDLE) || ((state_q == STOP) && bit_end_c);
  assign tmo_inc_c = tmo_q + TMO_W'(1);

  // Eligibility: a locked owner excludes the other requester entirely.
  always_comb begin
    sel_c     = rr_q;
    sel_vld_c = 1'b0;
    if (owner_q[0]) begin
      sel_c     = 1'b0;
      sel_vld_c = io_req0_valid;
    end else if (owner_q[1]) begin
      sel_c     = 1'b1;
      sel_vld_c = io_req1_valid;
    end else if (io_req0_valid && io_req1_valid) begin
      sel_c     = rr_q;
      sel_vld_c = 1'b1;
    end else if (io_req0_valid) begin
      sel_c     = 1'b0;
      sel_vld_c = 1'b1;
    end else if (io_req1_valid) begin
      sel_c     = 1'b1;
      sel_vld_c = 1'b1;
    end
  end

  assign accept_c      = window_c && sel_vld_c && reset;
  assign io_req0_ready = accept_c && !sel_c;
  assign io_req1_ready = accept_c && sel_c;
  assign acc_data_c    = sel_c ? io_req1_data : io_req0_data;
  assign acc_last_c    = sel_c ? io_req1_last : io_req0_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;

    case (state_q)
      IDLE: tx_d = 1'b1;
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept overrides both the frame tail and any simultaneous timeout expiry.
    if (accept_c) begin
      shift_d = acc_data_c;
      cnt_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      state_d = START;
      owner_d = acc_last_c ? 2'b00 : (sel_c ? 2'b10 : 2'b01);
      rr_d    = ~sel_c;
      tmo_d   = '0;
    end else if ((owner_q != 2'b00) && (state_q == IDLE) && !sel_vld_c) begin
      if (tmo_inc_c == TMO_W'(LOCK_TIMEOUT)) begin
        owner_d = 2'b00;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_inc_c;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      owner_q <= 2'b00;
      rr_q    <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign io_tx    = tx_q;
  assign io_busy  = busy_q;
  assign io_grant = owner_q;

endmodule
